// File: rtl/anti_theft_pkg.sv
// Shared anti-theft definitions: state encoding, default delays, timer width.
// The fuel pump logic and the timebase import the same package.
package anti_theft_pkg;

  localparam int TW = 4;

  localparam int DEF_T_ARM_DELAY       = 6;
  localparam int DEF_T_DRIVER_DELAY    = 8;
  localparam int DEF_T_PASSENGER_DELAY = 15;
  localparam int DEF_T_ALARM_ON        = 10;

  typedef enum logic [2:0] {
    ARMED      = 3'd0,
    TRIGGERED  = 3'd1,
    SOUND      = 3'd2,
    DISARMED   = 3'd3,
    WAIT_OPEN  = 3'd4,
    WAIT_CLOSE = 3'd5,
    ARM_DELAY  = 3'd6
  } state_t;

  // True for the states that keep the fuel pump locked out.
  function automatic logic is_guarding(input logic [2:0] s);
    return (s == ARMED) || (s == TRIGGERED) || (s == SOUND) || (s == 3'd7);
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Tick-driven countdown. Load has priority over a coincident tick, so the
// tick on the entry edge is never counted. Expiry is the tick seen at 1.
module alarm_timer
  import anti_theft_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          tick,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] value,
  output logic          expired
);

  assign expired = tick && (value == TW'(1));

  // Load, else count down on each tick until reaching zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     value <= '0;
    else if (load)                 value <= load_val;
    else if (tick && value != '0)  value <= value - TW'(1);
  end

endmodule

// File: rtl/anti_theft_alarm_fsm.sv
// Vehicle anti-theft FSM: arms after the driver leaves, triggers on door
// entry, sounds the siren if ignition stays off through the entry delay.
// Outputs are decoded from the registered state, one cycle behind it.
module anti_theft_alarm_fsm
  import anti_theft_pkg::*;
#(
  parameter int T_ARM_DELAY       = DEF_T_ARM_DELAY,
  parameter int T_DRIVER_DELAY    = DEF_T_DRIVER_DELAY,
  parameter int T_PASSENGER_DELAY = DEF_T_PASSENGER_DELAY,
  parameter int T_ALARM_ON        = DEF_T_ALARM_ON
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       ignition,
  input  logic       driver_door,
  input  logic       passenger_door,
  output logic       siren,
  output logic       status_led,
  output logic       vehicle_armed,
  output logic [2:0] state_dbg
);

  state_t        state;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic [TW-1:0] tmr_cnt;
  logic          tmr_exp;
  logic          door_open;

  assign door_open = driver_door | passenger_door;
  assign state_dbg = state;

  alarm_timer u_timer (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_cnt),
    .expired  (tmr_exp)
  );

  // Timer loads on entry to a timed state; SOUND also holds it while a door is open.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (!ignition) begin
      case (state)
        ARMED: begin
          if (driver_door) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(T_DRIVER_DELAY);
          end else if (passenger_door) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(T_PASSENGER_DELAY);
          end
        end
        TRIGGERED: if (tmr_exp) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(T_ALARM_ON);
        end
        SOUND: if (door_open) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(T_ALARM_ON);
        end
        WAIT_CLOSE: if (!driver_door) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(T_ARM_DELAY);
        end
        default: ;
      endcase
    end
  end

  // State register plus output decode of the current (pre-transition) state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ARMED;
      siren         <= 1'b0;
      status_led    <= 1'b0;
      vehicle_armed <= 1'b1;
    end else begin
      siren         <= (state == SOUND);
      vehicle_armed <= is_guarding(state);
      case (state)
        ARMED:            if (tick) status_led <= ~status_led;
        TRIGGERED, SOUND: status_led <= 1'b1;
        default:          status_led <= 1'b0;
      endcase

      if (ignition) state <= DISARMED;
      else begin
        case (state)
          ARMED:      if (door_open) state <= TRIGGERED;
          TRIGGERED:  if (tmr_exp) state <= SOUND;
          SOUND:      if (!door_open && tmr_exp) state <= ARMED;
          DISARMED:   state <= WAIT_OPEN;
          WAIT_OPEN:  if (driver_door) state <= WAIT_CLOSE;
          WAIT_CLOSE: if (!driver_door) state <= ARM_DELAY;
          ARM_DELAY: begin
            if (door_open)    state <= WAIT_CLOSE;
            else if (tmr_exp) state <= ARMED;
          end
          default:    state <= ARMED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anti_theft_alarm_fsm.sv
// Bench for anti_theft_alarm_fsm: directed scenarios with literal
// expectations, then randomized traffic, all shadowed by a behavioural model.
module tb_anti_theft_alarm_fsm;

  logic       clock = 1'b0, reset = 1'b0, tick = 1'b0, ignition = 1'b0;
  logic       driver_door = 1'b0, passenger_door = 1'b0;
  logic       siren, status_led, vehicle_armed;
  logic [2:0] state_dbg;

  int checks = 0, errors = 0;
  bit cmp_en = 0;

  anti_theft_alarm_fsm dut (
    .clock(clock), .reset(reset), .tick(tick), .ignition(ignition),
    .driver_door(driver_door), .passenger_door(passenger_door),
    .siren(siren), .status_led(status_led), .vehicle_armed(vehicle_armed),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // Behavioural model: mode 0..6 plus ticks left before the pending deadline.
  // Outputs describe the mode held during the previous cycle.
  int mode = 0, left = 0;
  bit m_siren = 0, m_led = 0, m_armed = 1;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mode = 0; left = 0; m_siren = 0; m_led = 0; m_armed = 1;
    end else begin
      m_siren = (mode == 2);
      m_armed = (mode <= 2);
      if (mode == 0) m_led = tick ? !m_led : m_led;
      else m_led = (mode == 1 || mode == 2);
      if (ignition) mode = 3;
      else case (mode)
        0: if (driver_door) begin mode = 1; left = 8; end
           else if (passenger_door) begin mode = 1; left = 15; end
        1: if (tick) begin
             left--;
             if (left == 0) begin mode = 2; left = 10; end
           end
        2: if (driver_door || passenger_door) left = 10;
           else if (tick) begin left--; if (left == 0) mode = 0; end
        3: mode = 4;
        4: if (driver_door) mode = 5;
        5: if (!driver_door) begin mode = 6; left = 6; end
        6: if (driver_door || passenger_door) mode = 5;
           else if (tick) begin left--; if (left == 0) mode = 0; end
        default: mode = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: DUT against the model.
  always @(negedge clock) if (cmp_en) begin
    chk("model_state", {29'd0, state_dbg}, mode);
    chk("model_siren", {31'd0, siren}, {31'd0, m_siren});
    chk("model_led", {31'd0, status_led}, {31'd0, m_led});
    chk("model_armed", {31'd0, vehicle_armed}, {31'd0, m_armed});
  end

  task automatic cyc(); @(negedge clock); #1; endtask

  task automatic do_reset();
    reset = 1; tick = 0; ignition = 0; driver_door = 0; passenger_door = 0;
    cyc(); cyc(); reset = 0; cyc();
  endtask

  task automatic pulse_tick(); tick = 1; cyc(); tick = 0; cyc(); endtask

  // Apply ticks (with idle gaps) until the state leaves st; returns tick count.
  task automatic count_ticks(input int st, output int n);
    n = 0;
    while (state_dbg == st[2:0] && n < 64) begin
      tick = 1; cyc(); tick = 0; n++;
      if (state_dbg == st[2:0]) cyc();
    end
  endtask

  int n, toggles;
  bit prev, seen;

  initial begin
    #1 reset = 1; cmp_en = 1;
    cyc(); cyc();
    chk("reset_state", {29'd0, state_dbg}, 0);
    chk("reset_armed", {31'd0, vehicle_armed}, 1);
    chk("reset_siren", {31'd0, siren}, 0);
    reset = 0; cyc();

    // 1: blink in ARMED
    toggles = 0; prev = status_led;
    for (int i = 0; i < 10; i++) begin
      tick = 1; cyc(); tick = 0;
      if (status_led != prev) toggles++;
      prev = status_led; cyc();
    end
    chk("led_toggles", toggles, 10);

    // 2: driver door entry delay
    do_reset();
    driver_door = 1; cyc(); driver_door = 0;
    chk("drv_trig", {29'd0, state_dbg}, 1);
    count_ticks(1, n);
    chk("drv_delay", n, 8);
    chk("drv_sound", {29'd0, state_dbg}, 2);
    chk("siren_lag", {31'd0, siren}, 0);
    cyc();
    chk("siren_on", {31'd0, siren}, 1);

    // 3a: passenger entry, ignition on at tick 5
    do_reset();
    passenger_door = 1; cyc(); passenger_door = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin pulse_tick(); seen |= siren; end
    ignition = 1; tick = 1; cyc(); tick = 0; seen |= siren;
    chk("ign_disarm", {29'd0, state_dbg}, 3);
    ignition = 0; cyc(); seen |= siren; cyc(); seen |= siren;
    chk("ign_wait_open", {29'd0, state_dbg}, 4);
    chk("ign_no_siren", {31'd0, seen}, 0);

    // 3b: passenger entry without ignition
    do_reset();
    passenger_door = 1; cyc(); passenger_door = 0;
    count_ticks(1, n);
    chk("pas_delay", n, 15);
    cyc();
    chk("pas_siren", {31'd0, siren}, 1);

    // 4: door held open in SOUND, then closed
    do_reset();
    driver_door = 1; cyc(); driver_door = 0;
    count_ticks(1, n);
    driver_door = 1; cyc();
    seen = 1;
    for (int i = 0; i < 20; i++) begin pulse_tick(); seen &= siren; end
    chk("hold_siren", {31'd0, seen}, 1);
    chk("hold_state", {29'd0, state_dbg}, 2);
    driver_door = 0; cyc();
    count_ticks(2, n);
    chk("alarm_on_ticks", n, 10);
    chk("alarm_rearm", {29'd0, state_dbg}, 0);
    cyc();
    chk("alarm_off", {31'd0, siren}, 0);

    // 5: disarm / re-arm with a reopen at tick 3
    do_reset();
    ignition = 1; cyc(); chk("seq_dis", {29'd0, state_dbg}, 3);
    ignition = 0; cyc(); chk("seq_wopen", {29'd0, state_dbg}, 4);
    driver_door = 1; cyc(); chk("seq_wclose", {29'd0, state_dbg}, 5);
    driver_door = 0; cyc(); chk("seq_armdly", {29'd0, state_dbg}, 6);
    pulse_tick(); pulse_tick();
    driver_door = 1; tick = 1; cyc(); tick = 0;
    chk("seq_reopen", {29'd0, state_dbg}, 5);
    driver_door = 0; cyc();
    count_ticks(6, n);
    chk("seq_arm_ticks", n, 6);
    chk("seq_armed", {29'd0, state_dbg}, 0);

    // 6: both doors together, then async reset during SOUND
    do_reset();
    driver_door = 1; passenger_door = 1; cyc();
    driver_door = 0; passenger_door = 0;
    count_ticks(1, n);
    chk("both_delay", n, 8);
    cyc();
    chk("both_siren", {31'd0, siren}, 1);
    reset = 1; #1;
    chk("async_siren", {31'd0, siren}, 0);
    chk("async_state", {29'd0, state_dbg}, 0);
    cyc(); reset = 0; cyc();

    // Randomized traffic
    for (int i = 0; i < 5000; i++) begin
      tick = ($urandom_range(3) == 0);
      if (ignition) ignition = ($urandom_range(2) != 0);
      else ignition = ($urandom_range(80) == 0);
      if ($urandom_range(7) == 0) driver_door = !driver_door;
      if ($urandom_range(9) == 0) passenger_door = !passenger_door;
      reset = ($urandom_range(700) == 0);
      cyc();
    end
    reset = 0; cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
